// File: rtl/oled_pkg.sv
// Shared geometry, pattern codes and FSM encoding for the OLED test-pattern source.
package oled_pkg;

    localparam int unsigned OLED_COLS      = 128;
    localparam int unsigned OLED_PAGES     = 8;
    localparam int unsigned OLED_ROWS      = 64;
    localparam int unsigned OLED_BUF_BYTES = 1024;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned COL_W   = 7;
    localparam int unsigned PAGE_W  = 3;
    localparam int unsigned ROW_W   = 6;
    localparam int unsigned COORD_W = 9;
    localparam int unsigned PAT_W   = 3;

    localparam logic [PAT_W-1:0] PAT_OFF   = 3'd0;
    localparam logic [PAT_W-1:0] PAT_ON    = 3'd1;
    localparam logic [PAT_W-1:0] PAT_CHECK = 3'd2;
    localparam logic [PAT_W-1:0] PAT_VBAR  = 3'd3;
    localparam logic [PAT_W-1:0] PAT_HBAR  = 3'd4;
    localparam logic [PAT_W-1:0] PAT_DIAG  = 3'd5;
    localparam logic [PAT_W-1:0] PAT_BOX   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Auto-cycle order runs PAT_ON..PAT_BOX and wraps back to PAT_ON.
    function automatic logic [PAT_W-1:0] next_cycle_pattern(input logic [PAT_W-1:0] p);
        return (p >= PAT_BOX) ? PAT_ON : PAT_W'(p + 3'd1);
    endfunction

endpackage

// File: rtl/oled_pattern_byte.sv
// Combinational generator for one page-column byte: bit b is the pixel at row page*8+b.
module oled_pattern_byte
    import oled_pkg::*;
#(
    parameter int unsigned BOX_SIZE = 16
) (
    input  logic [COL_W-1:0]  col,
    input  logic [PAGE_W-1:0] page,
    input  logic [7:0]        offset,
    input  logic [COL_W-1:0]  bx,
    input  logic [ROW_W-1:0]  by,
    input  logic [PAT_W-1:0]  mode,
    output logic [7:0]        pixels
);

    localparam logic [COORD_W-1:0] BOX9 = COORD_W'(BOX_SIZE);

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] off9;
    logic [COORD_W-1:0] bx9;
    logic [COORD_W-1:0] by9;

    assign x    = COORD_W'(col);
    assign off9 = COORD_W'(offset);
    assign bx9  = COORD_W'(bx);
    assign by9  = COORD_W'(by);

    // "mod 16 < 8" is simply bit 3 of the sum being clear.
    function automatic logic pixel_on(
        input logic [PAT_W-1:0]   m,
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py,
        input logic [COORD_W-1:0] off,
        input logic [COORD_W-1:0] box_x,
        input logic [COORD_W-1:0] box_y
    );
        logic [COORD_W-1:0] s;
        logic               on;
        s  = '0;
        on = 1'b0;
        case (m)
            PAT_ON:    on = 1'b1;
            PAT_CHECK: on = px[3] ^ py[3];
            PAT_VBAR:  begin s = px + off;      on = ~s[3]; end
            PAT_HBAR:  begin s = py + off;      on = ~s[3]; end
            PAT_DIAG:  begin s = px + py + off; on = ~s[3]; end
            PAT_BOX:   on = (px >= box_x) && (px < box_x + BOX9) &&
                            (py >= box_y) && (py < box_y + BOX9);
            default:   on = 1'b0;
        endcase
        return on;
    endfunction

    always_comb begin
        pixels = '0;
        for (int b = 0; b < 8; b++) begin
            pixels[b] = pixel_on(mode, x, COORD_W'({page, 3'(b)}), off9, bx9, by9);
        end
    end

endmodule

// File: rtl/oled_pattern_writer.sv
// Writes one full 128x64 page-major frame into the SSD1306 driver buffer per update request,
// with animation state (frame counter, bouncing box, auto-cycle) stepped once per frame.
module oled_pattern_writer
    import oled_pkg::*;
#(
    parameter int unsigned FRAMES_PER_PATTERN = 90,
    parameter int unsigned BOX_SIZE           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update_request,
    input  logic [PAT_W-1:0]  pattern_sel,
    input  logic              auto_cycle,
    input  logic              invert,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_data,
    output logic              buf_write,
    output logic              busy,
    output logic              frame_done,
    output logic [PAT_W-1:0]  active_pattern,
    output logic [7:0]        drop_count
);

    localparam logic [COL_W-1:0]  BX_MAX   = COL_W'(OLED_COLS - BOX_SIZE);
    localparam logic [ROW_W-1:0]  BY_MAX   = ROW_W'(OLED_ROWS - BOX_SIZE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OLED_BUF_BYTES - 1);
    localparam logic [7:0]        CYC_LAST = 8'(FRAMES_PER_PATTERN - 1);

    state_e             state;
    logic [ADDR_W-1:0]  idx;
    logic               inv_q;
    logic [7:0]         offset_q;
    logic [7:0]         frame_count;
    logic [COL_W-1:0]   bx;
    logic [ROW_W-1:0]   by;
    logic               dir_x;
    logic               dir_y;
    logic [7:0]         cycle_cnt;
    logic [PAT_W-1:0]   cycle_pat;
    logic               auto_prev;
    logic               auto_rise;
    logic [PAT_W-1:0]   cycle_pat_eff;
    logic [7:0]         pixels;

    assign auto_rise     = auto_cycle & ~auto_prev;
    assign cycle_pat_eff = auto_rise ? PAT_ON : cycle_pat;

    oled_pattern_byte #(
        .BOX_SIZE(BOX_SIZE)
    ) u_byte (
        .col    (idx[COL_W-1:0]),
        .page   (idx[ADDR_W-1:COL_W]),
        .offset (offset_q),
        .bx     (bx),
        .by     (by),
        .mode   (active_pattern),
        .pixels (pixels)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            inv_q          <= 1'b0;
            offset_q       <= '0;
            frame_count    <= '0;
            bx             <= '0;
            by             <= '0;
            dir_x          <= 1'b1;
            dir_y          <= 1'b1;
            cycle_cnt      <= '0;
            cycle_pat      <= PAT_ON;
            auto_prev      <= 1'b0;
            buf_addr       <= '0;
            buf_data       <= '0;
            buf_write      <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            active_pattern <= PAT_OFF;
            drop_count     <= '0;
        end else begin
            auto_prev  <= auto_cycle;
            buf_write  <= 1'b0;
            frame_done <= 1'b0;

            // Requests arriving mid-frame are counted and discarded.
            if (update_request && (state != ST_IDLE) && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end

            if (auto_rise) begin
                cycle_pat <= PAT_ON;
                cycle_cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (update_request) begin
                        state <= ST_LATCH;
                        busy  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    active_pattern <= auto_cycle ? cycle_pat_eff : pattern_sel;
                    inv_q          <= invert;
                    offset_q       <= frame_count;
                    idx            <= '0;
                    state          <= ST_WRITE;
                end
                ST_WRITE: begin
                    buf_write <= 1'b1;
                    buf_addr  <= idx;
                    buf_data  <= pixels ^ {8{inv_q}};
                    idx       <= idx + ADDR_W'(1);
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy        <= 1'b0;
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                    state       <= ST_IDLE;

                    if (dir_x) begin
                        if (bx == BX_MAX) begin
                            dir_x <= 1'b0;
                            bx    <= BX_MAX - COL_W'(1);
                        end else begin
                            bx <= bx + COL_W'(1);
                        end
                    end else begin
                        if (bx == '0) begin
                            dir_x <= 1'b1;
                            bx    <= COL_W'(1);
                        end else begin
                            bx <= bx - COL_W'(1);
                        end
                    end

                    if (dir_y) begin
                        if (by == BY_MAX) begin
                            dir_y <= 1'b0;
                            by    <= BY_MAX - ROW_W'(1);
                        end else begin
                            by <= by + ROW_W'(1);
                        end
                    end else begin
                        if (by == '0) begin
                            dir_y <= 1'b1;
                            by    <= ROW_W'(1);
                        end else begin
                            by <= by - ROW_W'(1);
                        end
                    end

                    // A fresh auto_cycle rise overrides the step and restarts at PAT_ON.
                    if (auto_cycle && !auto_rise) begin
                        if (cycle_cnt == CYC_LAST) begin
                            cycle_cnt <= '0;
                            cycle_pat <= next_cycle_pattern(cycle_pat);
                        end else begin
                            cycle_cnt <= cycle_cnt + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_pattern_writer.sv
// Directed bench for oled_pattern_writer: frame timing, pattern bytes, drops, reset, auto-cycle, box bounce.
module tb_oled_pattern_writer;

    logic       clk;
    logic       rst;
    logic       update_request;
    logic [2:0] pattern_sel;
    logic       auto_cycle;
    logic       invert;
    logic [9:0] buf_addr;
    logic [7:0] buf_data;
    logic       buf_write;
    logic       busy;
    logic       frame_done;
    logic [2:0] active_pattern;
    logic [7:0] drop_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] cap [1024];
    int nw, first_k, last_k, done_k, order_err, busy_latch;

    oled_pattern_writer #(
        .FRAMES_PER_PATTERN(2),
        .BOX_SIZE(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .update_request (update_request),
        .pattern_sel    (pattern_sel),
        .auto_cycle     (auto_cycle),
        .invert         (invert),
        .buf_addr       (buf_addr),
        .buf_data       (buf_data),
        .buf_write      (buf_write),
        .busy           (busy),
        .frame_done     (frame_done),
        .active_pattern (active_pattern),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issues one request, captures every written byte; k counts edges after the request edge.
    task automatic run_frame(input int drops);
        int dropped;
        dropped = 0; nw = 0; first_k = -1; last_k = -1; done_k = -1;
        order_err = 0; busy_latch = 0;
        @(negedge clk);
        update_request = 1'b1;
        for (int k = 0; k < 1100 && done_k < 0; k++) begin
            @(negedge clk);
            if (k == 1) busy_latch = int'(busy);
            if (buf_write) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                if (buf_addr != 10'(nw)) order_err++;
                if (nw < 1024) cap[nw] = buf_data;
                nw++;
            end
            if (frame_done) done_k = k;
            update_request = 1'b0;
            if (dropped < drops && k >= 10 && k < 1000 && (k % 3) == 1) begin
                update_request = 1'b1;
                dropped++;
            end
        end
        update_request = 1'b0;
        check("frame_done_seen", 32'(done_k >= 0), 32'd1);
    endtask

    int exp_auto [13] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 1};
    int not_ff;
    logic found;

    initial begin
        rst = 1'b1; update_request = 1'b0; pattern_sel = 3'd0; auto_cycle = 1'b0; invert = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr",   32'(buf_addr), 32'd0);
        check("rst_data",   32'(buf_data), 32'd0);
        check("rst_write",  32'(buf_write), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(frame_done), 32'd0);
        check("rst_active", 32'(active_pattern), 32'd0);
        check("rst_drops",  32'(drop_count), 32'd0);
        rst = 1'b0;

        // frame_count 0: horizontal stripes
        pattern_sel = 3'd4;
        run_frame(0);
        check("hbar0_p0",   32'(cap[0]), 32'hFF);
        check("hbar0_p0e",  32'(cap[127]), 32'hFF);
        check("hbar0_p1",   32'(cap[128]), 32'h00);
        check("hbar_active", 32'(active_pattern), 32'd4);

        // frame_count 1: all-on with full timing checks
        pattern_sel = 3'd1;
        run_frame(0);
        check("first_write",  32'(first_k), 32'd2);
        check("last_write",   32'(last_k), 32'd1025);
        check("done_cycle",   32'(done_k), 32'd1026);
        check("write_count",  32'(nw), 32'd1024);
        check("addr_order",   32'(order_err), 32'd0);
        check("busy_latch",   32'(busy_latch), 32'd1);
        check("busy_after",   32'(busy), 32'd0);
        not_ff = 0;
        for (int i = 0; i < 1024; i++) if (cap[i] != 8'hFF) not_ff++;
        check("all_ff_bytes", 32'(not_ff), 32'd0);
        check("on_active",    32'(active_pattern), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(frame_done), 32'd0);

        // frame_count 2/3: checkerboard, plain then inverted
        pattern_sel = 3'd2;
        run_frame(0);
        check("chk_a0",   32'(cap[0]), 32'h00);
        check("chk_a8",   32'(cap[8]), 32'hFF);
        check("chk_a128", 32'(cap[128]), 32'hFF);
        check("chk_a136", 32'(cap[136]), 32'h00);
        invert = 1'b1;
        run_frame(0);
        invert = 1'b0;
        check("inv_a0",   32'(cap[0]), 32'hFF);
        check("inv_a8",   32'(cap[8]), 32'h00);
        check("inv_a128", 32'(cap[128]), 32'h00);
        check("inv_a136", 32'(cap[136]), 32'hFF);

        // frame_count 4: stripes shifted by 4, three requests dropped mid-frame
        pattern_sel = 3'd4;
        run_frame(3);
        check("hbar4_p0",     32'(cap[0]), 32'h0F);
        check("hbar4_p1",     32'(cap[128]), 32'hF0);
        check("drops3",       32'(drop_count), 32'd3);
        check("drops3_writes", 32'(nw), 32'd1024);
        check("drops3_order", 32'(order_err), 32'd0);

        // frame_count 5: vertical bars, 300 more drops saturate the counter
        pattern_sel = 3'd3;
        run_frame(300);
        check("vbar_c0",  32'(cap[0]), 32'hFF);
        check("vbar_c3",  32'(cap[3]), 32'h00);
        check("vbar_c10", 32'(cap[10]), 32'h00);
        check("vbar_c11", 32'(cap[11]), 32'hFF);
        check("drops_sat", 32'(drop_count), 32'd255);

        // frame_count 6: diagonal
        pattern_sel = 3'd5;
        run_frame(0);
        check("diag_a0",   32'(cap[0]), 32'h03);
        check("diag_a128", 32'(cap[128]), 32'hFC);

        // frame_count 7: reserved code
        pattern_sel = 3'd7;
        run_frame(0);
        check("rsvd_a0",    32'(cap[0]), 32'h00);
        check("rsvd_a1023", 32'(cap[1023]), 32'h00);

        // reset in the middle of a frame
        pattern_sel = 3'd1;
        @(negedge clk); update_request = 1'b1;
        @(negedge clk); update_request = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (buf_write && buf_addr == 10'd500) found = 1'b1;
        end
        check("reach_addr500", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_write",  32'(buf_write), 32'd0);
        check("mid_rst_busy",   32'(busy), 32'd0);
        check("mid_rst_drops",  32'(drop_count), 32'd0);
        check("mid_rst_addr",   32'(buf_addr), 32'd0);
        check("mid_rst_active", 32'(active_pattern), 32'd0);
        rst = 1'b0;

        // box at (0,0) on the first frame after reset
        pattern_sel = 3'd6;
        run_frame(0);
        check("box0_a0",   32'(cap[0]), 32'hFF);
        check("box0_a15",  32'(cap[15]), 32'hFF);
        check("box0_a128", 32'(cap[128]), 32'hFF);
        check("box0_a16",  32'(cap[16]), 32'h00);
        check("box0_a256", 32'(cap[256]), 32'h00);

        // auto-cycle with two frames per pattern
        auto_cycle = 1'b1;
        for (int i = 0; i < 13; i++) begin
            run_frame(0);
            check($sformatf("auto_pat%0d", i), 32'(active_pattern), 32'(exp_auto[i]));
        end
        auto_cycle = 1'b0;

        // 14 frames done since reset; advance to frame 48 where the box hits the bottom
        pattern_sel = 3'd6;
        for (int i = 0; i < 34; i++) run_frame(0);
        run_frame(0);
        check("box48_p6c48", 32'(cap[816]), 32'hFF);
        check("box48_p5c48", 32'(cap[688]), 32'h00);
        check("box48_p6c63", 32'(cap[831]), 32'hFF);
        check("box48_p6c64", 32'(cap[832]), 32'h00);
        check("box48_p6c47", 32'(cap[815]), 32'h00);
        check("box48_p7c48", 32'(cap[944]), 32'hFF);
        run_frame(0);
        check("box49_p5c49", 32'(cap[689]), 32'h80);
        check("box49_p7c49", 32'(cap[945]), 32'h7F);
        check("box49_p6c48", 32'(cap[816]), 32'h00);
        check("box49_p6c64", 32'(cap[832]), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
